// File: rtl/mac8_window_capture.sv
// mac8_window_capture: downstream stage of mac8.
//   Runs fixed WIN-product accumulation windows on the MAC and captures each window's 16-bit
//   sum. The MAC's active-low clear is pulsed between windows. Each sum is right-shifted by SHIFT,
//   narrowed to OUT_W bits, then queued in a DEPTH-entry FIFO with a valid/ready output.
//
// Optional feature: define MAC_WIN_SAT_EN to saturate the narrowed word at 2^OUT_W-1.
//   When it is undefined, the word is the truncated low OUT_W bits.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   en         run windows while high
//   mac_dout   mac8 accumulator value (unsigned)
//   mac_clr_n  drives mac8 rst; low clears the accumulator
//   acc_busy   high while the MAC accumulates; upstream presents operands
//   out_data   FIFO head word
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts the head when out_valid & out_ready
//   level      FIFO occupancy
//   ovf        sticky flag: a window was dropped because the FIFO was full
//   clr_ovf    synchronous clear of ovf

module mac8_window_capture #(
  parameter int unsigned WIN   = 4,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [15:0]              mac_dout,
  output logic                     mac_clr_n,
  output logic                     acc_busy,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     clr_ovf
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIN - 1);
  localparam logic [PtrW:0]   LevelFull = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StAccum, StCapture} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state. Dropping en aborts the window even on its last product.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (en) state_d = StAccum;
      end
      StAccum: begin
        if (!en) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCapture: begin
        cnt_d   = '0;
        state_d = en ? StAccum : StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode straight from the state flops; the MAC is only released while accumulating.
  always_comb begin
    mac_clr_n = 1'b0;
    acc_busy  = 1'b0;
    if (state_q == StAccum) begin
      mac_clr_n = 1'b1;
      acc_busy  = 1'b1;
    end
  end

  // Requantize the captured sum. MAC wrap is not detected.
  logic [15:0]      shifted;
  logic [OUT_W-1:0] word;

  assign shifted = mac_dout >> SHIFT;

`ifdef MAC_WIN_SAT_EN
  localparam logic [15:0] WordMax = 16'((32'd1 << OUT_W) - 32'd1);
  assign word = (shifted > WordMax) ? WordMax[OUT_W-1:0] : shifted[OUT_W-1:0];
`else
  assign word = shifted[OUT_W-1:0];
`endif

  // FIFO.
  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    level_q;
  logic             push, pop, drop, wr;

  assign push      = (state_q == StCapture);
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;
  // When full, a concurrent pop frees the slot the write pointer already points at.
  assign drop      = push & (level_q == LevelFull) & ~pop;
  assign wr        = push & ~drop;
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr) begin
        mem_q[wr_ptr_q] <= word;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr && !pop)      level_q <= level_q + 1'b1;
      else if (!wr && pop) level_q <= level_q - 1'b1;
    end
  end

  // Setting wins over clearing in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac8_window_capture.sv
module tb_mac8_window_capture;

  localparam int WIN   = 4;
  localparam int SHIFT = 0;
  localparam int OUT_W = 8;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en, out_ready, clr_ovf;
  logic [15:0]            mac_dout;
  logic                   mac_clr_n, acc_busy, out_valid, ovf;
  logic [OUT_W-1:0]       out_data;
  logic [$clog2(DEPTH):0] level;
  logic [7:0]             din0, din1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: window position (-1 idle, 0..WIN-1 accumulating, WIN capture),
  // running window sum, FIFO contents and sticky overflow.
  int   m_pos;
  int   m_sum;
  int   m_q[$];
  bit   m_ovf;

  always #5 clk = ~clk;

  mac8_window_capture #(
    .WIN  (WIN),
    .SHIFT(SHIFT),
    .OUT_W(OUT_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mac_dout (mac_dout),
    .mac_clr_n(mac_clr_n),
    .acc_busy (acc_busy),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level),
    .ovf      (ovf),
    .clr_ovf  (clr_ovf)
  );

  // Behavioural mac8: clear while its reset is low, otherwise add the presented product.
  logic [15:0] acc;
  always_ff @(posedge clk) begin
    if (!mac_clr_n) acc <= '0;
    else if (acc_busy) acc <= acc + 16'(din0) * 16'(din1);
  end
  assign mac_dout = acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int quant(input int unsigned v);
    int unsigned s;
    int unsigned mx;
    s  = v >> SHIFT;
    mx = (32'd1 << OUT_W) - 1;
`ifdef MAC_WIN_SAT_EN
    if (s > mx) return int'(mx);
`endif
    return int'(s & mx);
  endfunction

  task automatic model_reset();
    m_pos = -1;
    m_sum = 0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_step();
    bit push;
    bit pop;
    bit drop;
    int w;
    push = 1'b0;
    w    = 0;
    pop  = (m_q.size() != 0) && out_ready;
    if (m_pos < 0) begin
      m_sum = 0;
      m_pos = en ? 0 : -1;
    end else if (m_pos < WIN) begin
      m_sum = (m_sum + int'(din0) * int'(din1)) % 65536;
      if (!en) m_pos = -1;
      else if (m_pos == WIN - 1) m_pos = WIN;
      else m_pos = m_pos + 1;
    end else begin
      push  = 1'b1;
      w     = quant(m_sum);
      m_sum = 0;
      m_pos = en ? 0 : -1;
    end
    drop = push && (m_q.size() == DEPTH) && !pop;
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    if (!drop) begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(w);
    end
  endtask

  task automatic check_outputs();
    bit busy;
    busy = (m_pos >= 0) && (m_pos < WIN);
    check("acc_busy", acc_busy, busy);
    check("mac_clr_n", mac_clr_n, busy);
    check("level", level, m_q.size());
    check("out_valid", out_valid, m_q.size() != 0);
    check("ovf", ovf, m_ovf);
    if (m_q.size() != 0) check("out_data", out_data, m_q[0]);
  endtask

  // One clock: model follows the inputs seen at the edge; outputs checked 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int exp_b;

  initial begin
    rst = 1'b0; en = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; din0 = '0; din1 = '0;
    model_reset();
    #2;
    check("rst_level", level, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_mac_clr_n", mac_clr_n, 0);
    check("rst_acc_busy", acc_busy, 0);
    check("rst_ovf", ovf, 0);
    ticks(2);
    #2 rst = 1'b1;
    ticks(2);

    // Steady windows of 4*3.
    din0 = 8'd4; din1 = 8'd3; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) check("a_value", out_data, 48);
    end

    // Window sum 1600: saturated or truncated.
`ifdef MAC_WIN_SAT_EN
    exp_b = 255;
`else
    exp_b = 64;
`endif
    en = 1'b0; ticks(8);
    din0 = 8'd20; din1 = 8'd20; en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) check("b_value", out_data, exp_b);
    end
    en = 1'b0; ticks(8);

    // Overflow: five windows into a four-entry FIFO with no consumer.
    out_ready = 1'b0; din0 = 8'd4; din1 = 8'd7; en = 1'b1;
    ticks(25);
    en = 1'b0;
    ticks(3);
    check("c_level", level, 4);
    check("c_ovf", ovf, 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("c_ovf_clr", ovf, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("c_drain", out_data, 112);
      tick();
    end
    check("c_empty", out_valid, 0);

    // Abort after two accumulate cycles, then a clean window.
    din0 = 8'd4; din1 = 8'd3; en = 1'b1;
    ticks(2);
    en = 1'b0;
    ticks(2);
    check("d_no_push", level, 0);
    check("d_clr", mac_clr_n, 0);
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (out_valid) check("d_value", out_data, 48);
    end
    en = 1'b0; ticks(8);

    // Full FIFO with a pop during capture.
    out_ready = 1'b0; en = 1'b1;
    ticks(25);
    out_ready = 1'b1; en = 1'b0;
    tick();
    out_ready = 1'b0;
    check("e_level", level, 4);
    check("e_ovf", ovf, 0);
    out_ready = 1'b1; ticks(8);

    // Asynchronous reset mid-accumulation with two words queued.
    out_ready = 1'b0; en = 1'b1;
    ticks(13);
    check("f_pre_level", level, 2);
    #3 rst = 1'b0;
    #1;
    model_reset();
    check("f_level", level, 0);
    check("f_out_valid", out_valid, 0);
    check("f_mac_clr_n", mac_clr_n, 0);
    check("f_ovf", ovf, 0);
    en = 1'b0;
    ticks(2);
    #3 rst = 1'b1;
    ticks(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 15) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_ovf   = ($urandom_range(0, 31) == 0);
      din0      = 8'($urandom);
      din1      = 8'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
